// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Result and leading-zero blank mask are held stable between conversions.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_out_o,
  output logic [DIGITS-1:0]     blank_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned ShW  = BcdW + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // All digits above units blanked, units always shown.
  localparam logic [DIGITS-1:0] BlankRst = ~(DIGITS'(1));

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q;
  logic [ShW-1:0]      sr_q;
  logic [ShW-1:0]      sr_d;
  logic [ShW-1:0]      adj;
  logic [CntW-1:0]     cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BcdW-1:0]     bcd_q;
  logic [DIGITS-1:0]   blank_q;
  logic [DIGITS-1:0]   blank_d;
  logic [3:0]          nib;
  logic                allz;

  // Add-3 on every BCD nibble >= 5, then shift the whole register left.
  always_comb begin
    adj = sr_q;
    nib = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = sr_q[WIDTH + 4*i +: 4];
      if (nib >= 4'd5) begin
        adj[WIDTH + 4*i +: 4] = nib + 4'd3;
      end
    end
    sr_d = {adj[ShW-2:0], 1'b0};
  end

  // blank[i] set when digits i..DIGITS-1 of the shifted result are all zero.
  always_comb begin
    blank_d = '0;
    allz    = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      allz       = allz & (sr_d[WIDTH + 4*i +: 4] == 4'd0);
      blank_d[i] = allz;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BlankRst;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sr_q    <= {{BcdW{1'b0}}, bin_in_i};
            cnt_q   <= CntW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            bcd_q   <= sr_d[ShW-1 -: BcdW];
            blank_q <= blank_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign bcd_out_o = bcd_q;
  assign blank_o   = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus random and exhaustive
// conversions checked against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;
  localparam int          Lat    = WIDTH + 1;  // negedges from start drive to done sample

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   blank;

  int n_checks;
  int n_fail;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .bin_in_i  (bin_in),
    .busy_o    (busy),
    .done_o    (done),
    .bcd_out_o (bcd_out),
    .blank_o   (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_blank(input int v);
    ref_blank = {v < 100, v < 10, 1'b0};
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctrl busy/done=%b expected 00", {busy, done});
    end
    n_checks++;
    if (bcd_out !== 12'h000) begin
      n_fail++; $display("FAIL reset_bcd got %h expected 000", bcd_out);
    end
    n_checks++;
    if (blank !== 3'b110) begin
      n_fail++; $display("FAIL reset_blank got %b expected 110", blank);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, bcd_out, blank} !== {2'b00, 12'h000, 3'b110}) begin
      n_fail++;
      $display("FAIL post_reset_idle busy=%b done=%b bcd=%h blank=%b", busy, done, bcd_out, blank);
    end
  endtask

  // Exact cycle-by-cycle latency and busy window for the maximum input.
  task automatic test_max();
    logic [11:0] prev;
    prev   = bcd_out;
    start  = 1'b1;
    bin_in = 8'd255;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'd0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n_checks++;
      if ({busy, done} !== 2'b10 || bcd_out !== prev) begin
        n_fail++;
        $display("FAIL max_busy cyc=%0d busy=%b done=%b bcd=%h expected busy=1 done=0 bcd=%h",
                 i, busy, done, bcd_out, prev);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({busy, done} !== 2'b01) begin
      n_fail++; $display("FAIL max_done busy/done=%b expected 01", {busy, done});
    end
    n_checks++;
    if (bcd_out !== 12'h255 || blank !== 3'b000) begin
      n_fail++; $display("FAIL max_result bcd=%h blank=%b expected 255/000", bcd_out, blank);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || bcd_out !== 12'h255) begin
      n_fail++; $display("FAIL max_done_drop done=%b bcd=%h expected 0/255", done, bcd_out);
    end
  endtask

  task automatic test_basic();
    int vals[10];
    int cyc;
    vals = '{0, 9, 100, 42, 10, 99, 0, 0, 0, 0};
    for (int k = 6; k < 10; k++) vals[k] = int'($urandom_range(255, 0));
    for (int k = 0; k < 10; k++) begin
      start  = 1'b1;
      bin_in = 8'(vals[k]);
      @(negedge clk);
      start  = 1'b0;
      bin_in = 8'($urandom);
      cyc    = 1;
      while (!done && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      n_checks++;
      if (done !== 1'b1 || cyc != Lat) begin
        n_fail++; $display("FAIL basic_latency val=%0d cycles=%0d expected %0d", vals[k], cyc, Lat);
      end
      n_checks++;
      if (bcd_out !== ref_bcd(vals[k]) || blank !== ref_blank(vals[k])) begin
        n_fail++;
        $display("FAIL basic_result val=%0d bcd=%h blank=%b expected %h/%b",
                 vals[k], bcd_out, blank, ref_bcd(vals[k]), ref_blank(vals[k]));
      end
      @(negedge clk);
    end
  endtask

  // Start and bin_in changes during busy must not disturb or queue a conversion.
  task automatic test_ignore_start();
    int dones;
    logic [11:0] res;
    dones  = 0;
    res    = '0;
    start  = 1'b1;
    bin_in = 8'd137;
    @(negedge clk);
    start  = 1'b0;
    for (int c = 1; c < 30; c++) begin
      if (c == 1) begin start = 1'b1; bin_in = 8'd200; end
      if (c == 2) start = 1'b0;
      if (c == 3) bin_in = 8'd77;
      @(negedge clk);
      if (done) begin dones++; res = bcd_out; end
      if (dones > 0 && !done) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL ignore_requeued busy=%b expected 0 at cyc %0d", busy, c);
        end
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL ignore_done_count got %0d expected 1", dones);
    end
    n_checks++;
    if (res !== 12'h137) begin
      n_fail++; $display("FAIL ignore_result got %h expected 137", res);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    int last_cyc;
    logic [11:0] held;
    dones    = 0;
    last_cyc = 0;
    held     = bcd_out;
    start    = 1'b1;
    bin_in   = 8'd58;
    for (int c = 1; c < 40 && dones < 2; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        n_checks++;
        if (dones == 1 && bcd_out !== 12'h058) begin
          n_fail++; $display("FAIL b2b_first got %h expected 058", bcd_out);
        end
        if (dones == 2 && bcd_out !== 12'h199) begin
          n_fail++; $display("FAIL b2b_second got %h expected 199", bcd_out);
        end
        if (dones == 2) begin
          n_checks++;
          if (c - last_cyc != Lat) begin
            n_fail++; $display("FAIL b2b_period got %0d expected %0d", c - last_cyc, Lat);
          end
          start = 1'b0;
        end
        last_cyc = c;
        held     = bcd_out;
        bin_in   = 8'd199;
      end else begin
        n_checks++;
        if (bcd_out !== held) begin
          n_fail++; $display("FAIL b2b_stable got %h expected %h", bcd_out, held);
        end
      end
    end
    n_checks++;
    if (dones != 2) begin
      n_fail++; $display("FAIL b2b_count got %0d expected 2", dones);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int cyc;
    start  = 1'b1;
    bin_in = 8'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (WIDTH) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || bcd_out !== 12'h077 || blank !== 3'b100) begin
      n_fail++; $display("FAIL abort_pre done=%b bcd=%h blank=%b expected 1/077/100",
                         done, bcd_out, blank);
    end
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd250;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bcd_out, blank} !== {2'b00, 12'h000, 3'b110}) begin
      n_fail++;
      $display("FAIL abort_state busy=%b done=%b bcd=%h blank=%b expected 0/0/000/110",
               busy, done, bcd_out, blank);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_done done=%b busy=%b expected 0/0", done, busy);
      end
    end
    start  = 1'b1;
    bin_in = 8'd250;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1 || bcd_out !== 12'h250 || blank !== 3'b000) begin
      n_fail++; $display("FAIL abort_after done=%b bcd=%h blank=%b expected 1/250/000",
                         done, bcd_out, blank);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int exp_q[$];
    int got;
    int nxt;
    int v;
    bit prev_done;
    got       = 0;
    prev_done = 1'b0;
    start     = 1'b1;
    bin_in    = 8'd0;
    exp_q.push_back(0);
    nxt = 1;
    for (int c = 0; c < 256 * Lat + 50 && got < 256; c++) begin
      @(negedge clk);
      if (done) begin
        n_checks++;
        if (prev_done || exp_q.size() == 0) begin
          n_fail++; $display("FAIL sweep_extra_done at cyc %0d", c);
        end else begin
          v = exp_q.pop_front();
          if (bcd_out !== ref_bcd(v) || blank !== ref_blank(v)) begin
            n_fail++;
            $display("FAIL sweep_result val=%0d bcd=%h blank=%b expected %h/%b",
                     v, bcd_out, blank, ref_bcd(v), ref_blank(v));
          end
        end
        got++;
        if (nxt < 256) begin
          bin_in = 8'(nxt);
          exp_q.push_back(nxt);
          nxt++;
        end else begin
          start = 1'b0;
        end
      end
      prev_done = done;
    end
    start = 1'b0;
    n_checks++;
    if (got != 256) begin
      n_fail++; $display("FAIL sweep_count got %0d expected 256", got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_max();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
